// File: rtl/spea_pack_pkg.sv
// Shared types and sizing for the two-segment bit packer.
package spea_pack_pkg;

    localparam int unsigned SEG_MAX        = 16;
    localparam int unsigned SEGS_PER_FRAME = 2;
    localparam int unsigned FRAME_W        = 64;
    localparam int unsigned LEN_W          = 5;
    localparam int unsigned IDX_W          = $clog2(SEG_MAX);
    localparam int unsigned PTR_W          = 7;
    localparam int unsigned CNT_W          = 2;
    localparam int unsigned BIT_W          = $clog2(FRAME_W);
    localparam int unsigned ACC_LIM        = SEG_MAX * SEGS_PER_FRAME;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT      = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_SEG_END   = 3'd3,
        ST_FRAME_END = 3'd4
    } state_e;

    typedef struct packed {
        logic [SEG_MAX-1:0] data;
        logic [LEN_W-1:0]   len;
    } seg_t;

    // Out-of-range lengths collapse to a full-width segment.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] raw);
        return (raw == '0 || raw > LEN_W'(SEG_MAX)) ? LEN_W'(SEG_MAX) : raw;
    endfunction

endpackage

// File: rtl/spea_pack_ser.sv
// Bit serializer: latches one segment and presents it LSB first, one bit per shift.
module spea_pack_ser
    import spea_pack_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic shift_en,
    input  seg_t seg_in,
    output logic bit_c,
    output logic last_c
);

    logic [SEG_MAX-1:0] data_q, data_d;
    logic [LEN_W-1:0]   len_q,  len_d;
    logic [IDX_W-1:0]   idx_q,  idx_d;

    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        idx_d  = idx_q;
        if (load) begin
            data_d = seg_in.data;
            len_d  = eff_len(seg_in.len);
            idx_d  = '0;
        end else if (shift_en) begin
            idx_d  = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
            idx_q  <= idx_d;
        end
    end

    assign bit_c  = data_q[idx_q];
    assign last_c = (LEN_W'(idx_q) == len_q - LEN_W'(1));

endmodule

// File: rtl/spea_pack.sv
// Packs two variable-length segments into a 64-bit stream with a segment-end mask.
module spea_pack
    import spea_pack_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SEG_MAX-1:0]  seg_data,
    input  logic [LEN_W-1:0]    seg_len,
    input  logic                seg_valid,
    output logic                seg_ready,
    output logic [FRAME_W-1:0]  out_B,
    output logic [FRAME_W-1:0]  out_S,
    output logic                done,
    output logic                done_spea
);

    state_e              state_q, state_d;
    logic [FRAME_W-1:0]  acc_b_q, acc_b_d;
    logic [FRAME_W-1:0]  acc_s_q, acc_s_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    seg_cnt_q, seg_cnt_d;
    logic [FRAME_W-1:0]  out_b_q, out_b_d;
    logic [FRAME_W-1:0]  out_s_q, out_s_d;
    logic                done_q, done_d;
    logic                done_spea_q, done_spea_d;
    logic                seg_ready_q, seg_ready_d;

    logic ser_load, ser_shift, ser_bit_c, ser_last_c;
    seg_t seg_in;

    assign seg_in = '{data: seg_data, len: seg_len};

    spea_pack_ser u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .shift_en (ser_shift),
        .seg_in   (seg_in),
        .bit_c    (ser_bit_c),
        .last_c   (ser_last_c)
    );

    always_comb begin
        state_d   = state_q;
        acc_b_d   = acc_b_q;
        acc_s_d   = acc_s_q;
        ptr_d     = ptr_q;
        seg_cnt_d = seg_cnt_q;
        out_b_d   = out_b_q;
        out_s_d   = out_s_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_b_d   = '0;
                    acc_s_d   = '0;
                    ptr_d     = '0;
                    seg_cnt_d = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (seg_valid && seg_ready_q) begin
                    ser_load = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Guard keeps the upper half of the accumulators permanently zero.
                ser_shift = 1'b1;
                if (ptr_q < PTR_W'(ACC_LIM)) begin
                    acc_b_d[ptr_q[BIT_W-1:0]] = ser_bit_c;
                    acc_s_d[ptr_q[BIT_W-1:0]] = ser_last_c;
                    ptr_d = ptr_q + PTR_W'(1);
                end
                if (ser_last_c) begin
                    state_d = ST_SEG_END;
                end
            end
            ST_SEG_END: begin
                seg_cnt_d = seg_cnt_q + CNT_W'(1);
                state_d   = (seg_cnt_d == CNT_W'(SEGS_PER_FRAME)) ? ST_FRAME_END : ST_WAIT;
            end
            ST_FRAME_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered so they line up with the state they describe.
        done_d      = (state_d == ST_SEG_END);
        done_spea_d = (state_d == ST_FRAME_END);
        seg_ready_d = (state_d == ST_WAIT);
        if (state_d == ST_FRAME_END) begin
            out_b_d = acc_b_q;
            out_s_d = acc_s_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            acc_b_q     <= '0;
            acc_s_q     <= '0;
            ptr_q       <= '0;
            seg_cnt_q   <= '0;
            out_b_q     <= '0;
            out_s_q     <= '0;
            done_q      <= 1'b0;
            done_spea_q <= 1'b0;
            seg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_b_q     <= acc_b_d;
            acc_s_q     <= acc_s_d;
            ptr_q       <= ptr_d;
            seg_cnt_q   <= seg_cnt_d;
            out_b_q     <= out_b_d;
            out_s_q     <= out_s_d;
            done_q      <= done_d;
            done_spea_q <= done_spea_d;
            seg_ready_q <= seg_ready_d;
        end
    end

    assign seg_ready = seg_ready_q;
    assign out_B     = out_b_q;
    assign out_S     = out_s_q;
    assign done      = done_q;
    assign done_spea = done_spea_q;

endmodule

// File: tb/tb_spea_pack.sv
// Randomized self-checking bench for spea_pack against a frame-level reference model.
module tb_spea_pack;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] seg_data;
    logic [4:0]  seg_len;
    logic        seg_valid;
    logic        seg_ready;
    logic [63:0] out_B;
    logic [63:0] out_S;
    logic        done;
    logic        done_spea;

    int          n_chk;
    int          n_bad;
    int          cyc;
    logic [63:0] last_b;
    logic [63:0] last_s;

    spea_pack dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seg_data  (seg_data),
        .seg_len   (seg_len),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .out_B     (out_B),
        .out_S     (out_S),
        .done      (done),
        .done_spea (done_spea)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int model_len(input logic [4:0] r);
        return (r == 5'd0 || r > 5'd16) ? 16 : int'(r);
    endfunction

    // Drives one frame, checking handshake/pulse timing every cycle and the packed result.
    task automatic run_frame(input logic [15:0] d0, input logic [4:0] r0,
                             input logic [15:0] d1, input logic [4:0] r1,
                             input bit noise, output int fs_cyc);
        int          l0, l1, steps, waits, acc, cd;
        bit          exp_rdy, exp_done, exp_fs, accept, n_rdy, n_done, n_fs;
        logic [63:0] eb, es, m0, m1;
        l0 = model_len(r0);
        l1 = model_len(r1);
        m0 = (64'd1 << l0) - 64'd1;
        m1 = (64'd1 << l1) - 64'd1;
        eb = ({48'd0, d0} & m0) | (({48'd0, d1} & m1) << l0);
        es = (64'd1 << (l0 - 1)) | (64'd1 << (l0 + l1 - 1));

        chk("idle_ready", 64'(seg_ready), 64'd0);
        start     = 1'b1;
        seg_valid = noise ? 1'($urandom_range(0, 1)) : 1'b1;
        seg_data  = 16'($urandom);
        seg_len   = 5'($urandom);
        step();
        start    = 1'b0;
        steps    = 1;
        waits    = 0;
        acc      = 0;
        cd       = 0;
        exp_rdy  = 1'b1;
        exp_done = 1'b0;
        exp_fs   = 1'b0;
        while (steps < 400) begin
            chk("seg_ready", 64'(seg_ready), 64'(exp_rdy));
            chk("done", 64'(done), 64'(exp_done));
            chk("done_spea", 64'(done_spea), 64'(exp_fs));
            if (exp_fs) break;
            chk("out_B_hold", out_B, last_b);
            chk("out_S_hold", out_S, last_s);

            accept = 1'b0;
            seg_valid = noise ? 1'($urandom_range(0, 1)) : 1'b1;
            if (exp_rdy) begin
                seg_data = (acc == 0) ? d0 : d1;
                seg_len  = (acc == 0) ? r0 : r1;
                if (seg_valid) accept = 1'b1;
                else waits++;
            end else begin
                seg_data = 16'($urandom);
                seg_len  = 5'($urandom);
            end
            if (noise) start = 1'($urandom_range(0, 1));
            step();
            steps++;

            n_rdy  = 1'b0;
            n_done = 1'b0;
            n_fs   = 1'b0;
            if (accept) begin
                cd = (acc == 0) ? l0 : l1;
                acc++;
            end else if (cd > 0) begin
                cd--;
                n_done = (cd == 0);
            end else if (exp_done) begin
                n_rdy = (acc < 2);
                n_fs  = (acc >= 2);
            end else if (exp_rdy) begin
                n_rdy = 1'b1;
            end
            exp_rdy  = n_rdy;
            exp_done = n_done;
            exp_fs   = n_fs;
        end
        fs_cyc = cyc;
        chk("out_B", out_B, eb);
        chk("out_S", out_S, es);
        // Edges from the start-sampling cycle to the FRAME_END cycle: full latency minus one.
        chk("latency", 64'(steps), 64'(5 + l0 + l1 + waits));
        last_b    = eb;
        last_s    = es;
        start     = 1'b0;
        seg_valid = noise ? 1'b0 : 1'b1;
        step();
    endtask

    initial begin
        int t0, t1, t2;
        n_chk     = 0;
        n_bad     = 0;
        cyc       = 0;
        last_b    = '0;
        last_s    = '0;
        rst       = 1'b0;
        start     = 1'b0;
        seg_valid = 1'b0;
        seg_data  = '0;
        seg_len   = '0;
        step();
        step();
        chk("rst_out_B", out_B, 64'd0);
        chk("rst_out_S", out_S, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_done_spea", 64'(done_spea), 64'd0);
        chk("rst_seg_ready", 64'(seg_ready), 64'd0);
        rst = 1'b1;
        step();

        seg_valid = 1'b1;
        seg_data  = 16'hFFFF;
        seg_len   = 5'd16;
        repeat (3) begin
            step();
            chk("idle_valid_ignored", 64'(seg_ready), 64'd0);
            chk("idle_valid_no_done", 64'(done), 64'd0);
        end

        run_frame(16'hABCD, 5'd16, 16'h0005, 5'd3, 1'b0, t0);
        chk("s1_out_B", out_B, 64'h0000_0000_0005_ABCD);
        chk("s1_out_S", out_S, 64'h0000_0000_0004_8000);

        run_frame(16'h0001, 5'd1, 16'h0000, 5'd1, 1'b0, t0);
        chk("s2_out_B", out_B, 64'h1);
        chk("s2_out_S", out_S, 64'h3);

        run_frame(16'hFFFF, 5'd0, 16'hFFFF, 5'd20, 1'b0, t0);
        chk("s3_out_B", out_B, 64'h0000_0000_FFFF_FFFF);
        chk("s3_out_S", out_S, 64'h0000_0000_8000_8000);

        run_frame(16'h1234, 5'd7, 16'hBEEF, 5'd12, 1'b1, t0);

        // Reset in the middle of segment 0 shifting.
        start     = 1'b1;
        seg_valid = 1'b1;
        seg_data  = 16'hFFFF;
        seg_len   = 5'd16;
        step();
        start = 1'b0;
        step();
        step();
        step();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_out_B", out_B, 64'd0);
        chk("mid_rst_out_S", out_S, 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_done_spea", 64'(done_spea), 64'd0);
        chk("mid_rst_seg_ready", 64'(seg_ready), 64'd0);
        step();
        step();
        rst    = 1'b1;
        last_b = '0;
        last_s = '0;
        repeat (3) begin
            step();
            chk("post_rst_needs_start", 64'(seg_ready), 64'd0);
            chk("post_rst_out_B", out_B, 64'd0);
        end
        run_frame(16'h0001, 5'd1, 16'h0000, 5'd1, 1'b0, t0);
        chk("s4_out_B", out_B, 64'h1);
        chk("s4_out_S", out_S, 64'h3);

        // Back-to-back frames with seg_valid held: done_spea spacing equals full latency.
        run_frame(16'h00F0, 5'd8, 16'h0A5A, 5'd13, 1'b0, t0);
        run_frame(16'hC3C3, 5'd16, 16'h0007, 5'd4, 1'b0, t1);
        chk("period_a", 64'(t1 - t0), 64'(6 + 16 + 4));
        run_frame(16'h0002, 5'd2, 16'h8001, 5'd31, 1'b0, t2);
        chk("period_b", 64'(t2 - t1), 64'(6 + 2 + 16));

        for (int i = 0; i < 25; i++) begin
            run_frame(16'($urandom), 5'($urandom), 16'($urandom), 5'($urandom),
                      1'($urandom_range(0, 1)), t0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
